cpu_ext_trace_clk_gen: RTL
==========================

# cpu_ext_trace_clk_gen

Parametrised multi-channel clock-enable generator for the Nios II external trace path. It replaces a fixed ×2 clock with NUM_CH independently programmable divided strobes and square waves, all derived from the single system clock. Each channel has run-time divide and phase settings, a global phase-resync, and a per-channel lock indicator. It sits between the CPU clock domain and the trace capture/output logic, which consume `clk_en` as a synchronous enable.

## Interface
- `NUM_CH`, default 2: number of output channels (1–8).
- `DIV_W`, default 8: width of the divide and phase fields.
- `DEFAULT_DIV`, default 2: divide ratio loaded into every channel at reset (1 to 2^DIV_W−1).
- `LOCK_CYCLES`, default 5: completed output periods after configuration before `locked` asserts (≥1).
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cfg_wr`  in  1  single-cycle configuration write strobe.
- `cfg_chan`  in  3  target channel for `cfg_wr`; values ≥ NUM_CH are ignored.
- `cfg_div`  in  DIV_W  divide ratio D; 0 disables the channel.
- `cfg_phase`  in  DIV_W  starting count P.
- `sync_all`  in  1  reload every enabled channel counter from its stored phase.
- `clk_en`  out  NUM_CH  per-channel one-cycle enable pulse, once per period.
- `clk_out`  out  NUM_CH  per-channel divided square wave.
- `locked`  out  NUM_CH  channel has run LOCK_CYCLES periods since its last write.

## Operation
- Per-channel state:
  - `div` (DIV_W bits).
  - `phase` (DIV_W bits).
  - `cnt` (DIV_W bits).
  - `lock_cnt`, saturating at LOCK_CYCLES.
- Enabled channel (D ≥ 1):
  - `cnt` counts 0..D−1. When `cnt == D−1` it wraps to 0; each such transition is a "wrap".
  - All outputs are flops loaded from the decode of the next `cnt` value, so during any cycle they reflect the current `cnt`.
  - `clk_en` = (`cnt == 0`).
  - `clk_out` = (`cnt < ceil(D/2)`). D=1 gives constant high for both `clk_en` and `clk_out`. D=3 gives 2 cycles high, 1 low.
- Disabled channel (D = 0): `cnt` held at 0; `clk_en`, `clk_out` and `locked` all 0.
- Config write (`cfg_wr`=1, `cfg_chan` < NUM_CH), at the edge:
  - Load `div` ← `cfg_div` and `phase` ← P', where P' = `cfg_phase` if `cfg_phase` < `cfg_div`, else 0.
  - Load `cnt` ← P' and clear `lock_cnt`. `locked` drops at that edge.
  - Other channels are unaffected.
- `sync_all`: every enabled channel loads `cnt` ← `phase` at the edge. `lock_cnt` is not cleared, and the load is not counted as a wrap.
- Lock:
  - Each wrap increments `lock_cnt`, saturating.
  - `locked[i]` is registered high on the edge where `lock_cnt` reaches LOCK_CYCLES, and stays high until the next write to that channel or reset.
- Simultaneous events:
  - `cfg_wr` + `sync_all` on the same edge: the written channel takes write semantics; all others resync.
  - A write that coincides with a wrap: the write wins and no lock increment occurs.
- Reset (asserted at any time, including mid-period):
  - `div` = DEFAULT_DIV, `phase` = 0, `cnt` = DEFAULT_DIV−1, `lock_cnt` = 0.
  - `clk_en`, `clk_out` and `locked` all 0 immediately, without waiting for a clock edge.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- First edge after reset release: `cnt` wraps to 0, so `clk_en` = 1 and `clk_out` = 1 in the following cycle. This counts as wrap 1.
- Write latency: the new pattern is visible in the cycle after the write edge, with `cnt` = P'.
- Write with P' = 0 and D = N at edge k: `clk_en` pulses in the cycles after edges k, k+N, k+2N, …
- Wraps occur at edges k+N·j. `locked` goes high in the cycle after edge k+N·LOCK_CYCLES.
- `sync_all` latency: 1 cycle. Channels with equal phase are then edge-aligned.

## Test plan
- Reset defaults (DEFAULT_DIV=2, LOCK_CYCLES=5): release `reset_n` → `clk_en` and `clk_out` toggle 1,0,1,0 on both channels; `locked` = 1 in the cycle after the 5th wrap (edge 9 after release).
- Write ch0 D=4, P=0 at edge k → `clk_en[0]` high after edges k, k+4, k+8; `clk_out[0]` pattern 1,1,0,0; `locked[0]` = 0 until after edge k+20; ch1 unchanged.
- Odd divide and phase: write ch1 D=3, P=2 → first cycle `cnt`=2 (`clk_en`=0, `clk_out`=0), then `clk_en` pulses every 3 cycles, `clk_out` 2 high / 1 low.
- Boundaries:
  - D=0 → ch outputs all 0.
  - D=1 → `clk_en` and `clk_out` constant 1.
  - P=5 with D=4 → loads P'=0.
  - `cfg_chan`=7 with NUM_CH=2 → no change anywhere.
- Resync: ch0 D=4 P=1, ch1 D=4 P=1 written at different times, then `sync_all` pulse → `clk_en` pulses coincide from then on; `locked` unaffected. Also `sync_all` coincident with a ch0 write → ch0 `locked` cleared, ch1 resynced.
- Mid-operation reset: assert `reset_n`=0 asynchronously while channels are locked → all outputs 0 before the next `clk` edge; reset-default behaviour resumes on release.

Source files
------------

// File: rtl/cpu_ext_trace_clk_gen_if.sv
// ---------------------------------------------------------------------------
// cpu_ext_trace_clk_gen_if
//
// Purpose : Bundles the configuration bus and the per-channel trace clock
//           outputs of cpu_ext_trace_clk_gen.
//
// Signals : cfg_wr     single-cycle configuration write strobe
//           cfg_chan   target channel of a write (values >= NUM_CH ignored)
//           cfg_div    divide ratio D (0 disables the channel)
//           cfg_phase  starting count P
//           sync_all   reload every enabled channel counter from its phase
//           clk_en     per-channel one-cycle enable pulse, once per period
//           clk_out    per-channel divided square wave
//           locked     per-channel "has run LOCK_CYCLES periods" flag
//
// Modports: master drives configuration and observes the outputs,
//           slave (the generator) receives configuration and drives outputs.
// ---------------------------------------------------------------------------
interface cpu_ext_trace_clk_gen_if #(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = 8
);

  logic              cfg_wr;
  logic [2:0]        cfg_chan;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic              sync_all;

  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] locked;

  modport master (
    output cfg_wr,
    output cfg_chan,
    output cfg_div,
    output cfg_phase,
    output sync_all,
    input  clk_en,
    input  clk_out,
    input  locked
  );

  modport slave (
    input  cfg_wr,
    input  cfg_chan,
    input  cfg_div,
    input  cfg_phase,
    input  sync_all,
    output clk_en,
    output clk_out,
    output locked
  );

endinterface

// File: rtl/cpu_ext_trace_clk_gen.sv
// ---------------------------------------------------------------------------
// cpu_ext_trace_clk_gen
//
// Purpose : Multi-channel clock-enable generator for the Nios II external
//           trace path. Each of NUM_CH channels divides the system clock by a
//           run-time programmable ratio with a programmable starting phase and
//           produces a one-cycle enable strobe, a square wave and a lock flag.
//
// Ports   : clk      system clock (only clock)
//           reset_n  asynchronous active-low reset
//           bus      cpu_ext_trace_clk_gen_if.slave
//                      in : cfg_wr, cfg_chan, cfg_div, cfg_phase, sync_all
//                      out: clk_en, clk_out, locked (all registered)
//
// Parameters:
//           NUM_CH       number of channels (1..8)
//           DIV_W        width of divide / phase fields
//           DEFAULT_DIV  divide ratio of every channel after reset
//           LOCK_CYCLES  completed periods after a write before locked rises
// ---------------------------------------------------------------------------
module cpu_ext_trace_clk_gen #(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  cpu_ext_trace_clk_gen_if.slave   bus
);

  localparam int                LOCK_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
  localparam logic [DIV_W-1:0]  DIV_RST  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0]  CNT_RST  = DIV_W'(DEFAULT_DIV - 1);

  // Per-channel registered state
  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  phase_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [LOCK_W-1:0] lock_q  [NUM_CH];
  logic [NUM_CH-1:0] en_q;
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] locked_q;

  // Next-state values
  logic [DIV_W-1:0]  div_d   [NUM_CH];
  logic [DIV_W-1:0]  phase_d [NUM_CH];
  logic [DIV_W-1:0]  cnt_d   [NUM_CH];
  logic [LOCK_W-1:0] lock_d  [NUM_CH];
  logic [NUM_CH-1:0] en_d;
  logic [NUM_CH-1:0] out_d;
  logic [NUM_CH-1:0] locked_d;

  // Helpers
  logic              wr_hit  [NUM_CH];
  logic [DIV_W-1:0]  wr_phase;
  logic [DIV_W:0]    half    [NUM_CH];

  // An out-of-range phase falls back to 0 so cnt always stays below div.
  always_comb begin
    wr_phase = (bus.cfg_phase < bus.cfg_div) ? bus.cfg_phase : '0;
  end

  // Channel next-state. Priority: write > disabled > resync > wrap > count.
  // A write therefore swallows a coincident wrap (no lock increment), and a
  // resync reloads cnt without counting as a wrap. Outputs are decoded from
  // the next state so the output flops line up with the new cnt.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_d[i]   = div_q[i];
      phase_d[i] = phase_q[i];
      cnt_d[i]   = cnt_q[i];
      lock_d[i]  = lock_q[i];
      wr_hit[i]  = bus.cfg_wr && (bus.cfg_chan == 3'(i));

      if (wr_hit[i]) begin
        div_d[i]   = bus.cfg_div;
        phase_d[i] = wr_phase;
        cnt_d[i]   = wr_phase;
        lock_d[i]  = '0;
      end else if (div_q[i] == '0) begin
        cnt_d[i] = '0;
      end else if (bus.sync_all) begin
        cnt_d[i] = phase_q[i];
      end else if (cnt_q[i] == div_q[i] - 1'b1) begin
        cnt_d[i] = '0;
        if (lock_q[i] != LOCK_MAX) begin
          lock_d[i] = lock_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end

      // ceil(D/2): the high portion of the square wave gets the odd cycle.
      half[i]     = ({1'b0, div_d[i]} + 1'b1) >> 1;
      en_d[i]     = (div_d[i] != '0) && (cnt_d[i] == '0);
      out_d[i]    = (div_d[i] != '0) && ({1'b0, cnt_d[i]} < half[i]);
      locked_d[i] = (div_d[i] != '0) && (lock_d[i] == LOCK_MAX);
    end
  end

  // State and output registers. Reset leaves cnt one below the default
  // divide so the first edge after release produces a wrap and a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_RST;
        phase_q[i] <= '0;
        cnt_q[i]   <= CNT_RST;
        lock_q[i]  <= '0;
      end
      en_q     <= '0;
      out_q    <= '0;
      locked_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= div_d[i];
        phase_q[i] <= phase_d[i];
        cnt_q[i]   <= cnt_d[i];
        lock_q[i]  <= lock_d[i];
      end
      en_q     <= en_d;
      out_q    <= out_d;
      locked_q <= locked_d;
    end
  end

  assign bus.clk_en  = en_q;
  assign bus.clk_out = out_q;
  assign bus.locked  = locked_q;

endmodule
